// File: rtl/background_scanner_pkg.sv
// Shared definitions for the background raster scanner: screen geometry,
// coordinate/colour widths, FSM state encoding and a clamping helper.
package background_scanner_pkg;

  localparam int SCREEN_H_RES = 320;
  localparam int SCREEN_V_RES = 240;
  localparam int COORD_W      = 9;
  localparam int COLOUR_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Limit an end coordinate to the last visible column/row.
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] value,
    input logic [COORD_W-1:0] limit
  );
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/background_scanner_pixel_delay.sv
// Fixed-depth shift register carrying {valid, x, y} so the coordinates line
// up with the colour the background generator returns LATENCY cycles later.
module pixel_delay
  import background_scanner_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
);

  localparam int STAGE_W = 1 + 2 * COORD_W;

  generate
    if (LATENCY == 0) begin : g_bypass
      assign {out_valid, out_x, out_y} = {in_valid, in_x, in_y};
    end else begin : g_line
      logic [STAGE_W-1:0] stage_reg [LATENCY];

      // Shift one stage per clock; stage 0 takes the freshly presented pixel.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < LATENCY; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= {in_valid, in_x, in_y};
          for (int i = 1; i < LATENCY; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign {out_valid, out_x, out_y} = stage_reg[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/background_scanner.sv
// Raster sequencer: sweeps an inclusive rectangle onto the background
// generator one pixel per clock, re-aligns the returned colour with the
// delayed coordinates and drives plot strobes to the VGA adapter.
module background_scanner
  import background_scanner_pkg::*;
#(
  parameter int H_RES   = SCREEN_H_RES,
  parameter int V_RES   = SCREEN_V_RES,
  parameter int LATENCY = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [COORD_W-1:0]  rx0,
  input  logic [COORD_W-1:0]  ry0,
  input  logic [COORD_W-1:0]  rx1,
  input  logic [COORD_W-1:0]  ry1,
  output logic [COORD_W-1:0]  x_cord,
  output logic [COORD_W-1:0]  y_cord,
  input  logic [COLOUR_W-1:0] flag,
  output logic [COORD_W-1:0]  vga_x,
  output logic [COORD_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);
  localparam int                 CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0]   FLUSH_LAST = CNT_W'(LATENCY);

  scan_state_t        state_reg;
  logic [COORD_W-1:0] x_start_reg;
  logic [COORD_W-1:0] x_end_reg;
  logic [COORD_W-1:0] y_end_reg;
  logic [CNT_W-1:0]   flush_cnt_reg;

  logic [COORD_W-1:0] rx1_clamped;
  logic [COORD_W-1:0] ry1_clamped;
  logic               empty_sweep;

  logic               dly_valid;
  logic [COORD_W-1:0] dly_x;
  logic [COORD_W-1:0] dly_y;

  // Request decode: clamp the far corner and detect rectangles with no pixels.
  always_comb begin
    rx1_clamped = clamp_coord(rx1, X_MAX);
    ry1_clamped = clamp_coord(ry1, Y_MAX);
    empty_sweep = (rx0 > rx1_clamped) || (ry0 > ry1_clamped) ||
                  (rx0 > X_MAX) || (ry0 > Y_MAX);
  end

  // Sweep FSM with coordinate counters; compare before increment so the
  // counters never step past the clamped end point.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      x_cord        <= '0;
      y_cord        <= '0;
      x_start_reg   <= '0;
      x_end_reg     <= '0;
      y_end_reg     <= '0;
      flush_cnt_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_start_reg <= rx0;
            x_end_reg   <= rx1_clamped;
            y_end_reg   <= ry1_clamped;
            busy        <= 1'b1;
            if (empty_sweep) begin
              // Out-of-range origins are never driven onto the generator.
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_SCAN;
              x_cord    <= rx0;
              y_cord    <= ry0;
            end
          end
        end
        ST_SCAN: begin
          if (x_cord == x_end_reg) begin
            if (y_cord == y_end_reg) begin
              state_reg     <= ST_FLUSH;
              flush_cnt_reg <= '0;
            end else begin
              x_cord <= x_start_reg;
              y_cord <= y_cord + COORD_W'(1);
            end
          end else begin
            x_cord <= x_cord + COORD_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  pixel_delay #(
    .LATENCY (LATENCY)
  ) u_pixel_delay (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (state_reg == ST_SCAN),
    .in_x      (x_cord),
    .in_y      (y_cord),
    .out_valid (dly_valid),
    .out_x     (dly_x),
    .out_y     (dly_y)
  );

  // Output stage: pair each delayed coordinate with the generator's colour.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x  <= '0;
      vga_y  <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= dly_valid;
      if (dly_valid) begin
        vga_x  <= dly_x;
        vga_y  <= dly_y;
        colour <= flag;
      end
    end
  end

endmodule

// File: tb/tb_background_scanner.sv
// Randomised scoreboard bench for background_scanner: a stand-in background
// generator, a rectangle-level expected-pixel model and a negedge monitor.
module tb_background_scanner;

  localparam int H   = 320;
  localparam int V   = 240;
  localparam int LAT = 1;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [8:0] rx0 = '0, ry0 = '0, rx1 = '0, ry1 = '0;
  logic [8:0] x_cord, y_cord, vga_x, vga_y;
  logic [2:0] flag = '0;
  logic [2:0] colour;
  logic       plot, busy, done;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_exp;
  int   cyc = 0;
  int   busy_lo = -10;
  int   done_at = -10;
  int   checks = 0;
  int   errors = 0;
  bit   exp_busy;

  background_scanner #(
    .H_RES   (H),
    .V_RES   (V),
    .LATENCY (LAT)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .rx0    (rx0),
    .ry0    (ry0),
    .rx1    (rx1),
    .ry1    (ry1),
    .x_cord (x_cord),
    .y_cord (y_cord),
    .flag   (flag),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in background picture: bands top and bottom, tiles elsewhere.
  function automatic logic [2:0] gen_colour(input int x, input int y);
    if (y >= 150 || y < 10) return 3'b111;
    return 3'((x >> 3) + (y >> 4));
  endfunction

  // Background generator with one cycle of registered latency.
  always @(posedge clock) flag <= gen_colour(int'(x_cord), int'(y_cord));

  // Monitor: reset values, busy/done timing, coordinate range, pixel order.
  always @(negedge clock) begin
    if (!resetn) begin
      checks++;
      if ({plot, busy, done, colour, vga_x, vga_y, x_cord, y_cord} != '0) begin
        errors++;
        $display("FAIL reset_zero: plot=%0d busy=%0d done=%0d colour=%0d vga=(%0d,%0d) cord=(%0d,%0d) required all 0",
                 plot, busy, done, colour, vga_x, vga_y, x_cord, y_cord);
      end
    end else begin
      exp_busy = (cyc >= busy_lo) && (cyc <= done_at);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: cycle %0d got %0d required %0d", cyc, busy, exp_busy);
      end
      checks++;
      if (done !== (cyc == done_at)) begin
        errors++;
        $display("FAIL done: cycle %0d got %0d required %0d (done due at %0d)", cyc, done, (cyc == done_at), done_at);
      end
      if (cyc == done_at) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL plot_count: at done %0d plots still outstanding, required 0 (next (%0d,%0d))",
                   exp_q.size(), exp_q[0].x, exp_q[0].y);
        end
      end
      checks++;
      if (x_cord >= 9'(H) || y_cord >= 9'(V)) begin
        errors++;
        $display("FAIL cord_range: got (%0d,%0d) required inside %0dx%0d", x_cord, y_cord, H, V);
      end
      if (plot) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_plot: cycle %0d got plot at (%0d,%0d) colour %0d, required none", cyc, vga_x, vga_y, colour);
        end else begin
          mon_exp = exp_q.pop_front();
          if (int'(vga_x) != mon_exp.x || int'(vga_y) != mon_exp.y || int'(colour) != mon_exp.c) begin
            errors++;
            $display("FAIL pixel: cycle %0d got (%0d,%0d) colour %0d required (%0d,%0d) colour %0d",
                     cyc, vga_x, vga_y, colour, mon_exp.x, mon_exp.y, mon_exp.c);
          end
        end
      end
    end
  end

  // Issue a sweep from a negedge+1 point; expected pixels come from the
  // rectangle rules, and busy/done windows from the pixel count.
  task automatic launch(input int a0, input int b0, input int a1, input int b1, input bit poke);
    int ex1, ey1, n;
    ex1 = (a1 > H - 1) ? H - 1 : a1;
    ey1 = (b1 > V - 1) ? V - 1 : b1;
    n = 0;
    if (!(a0 > ex1 || b0 > ey1 || a0 >= H || b0 >= V)) begin
      for (int y = b0; y <= ey1; y++)
        for (int x = a0; x <= ex1; x++) begin
          exp_q.push_back('{x, y, int'(gen_colour(x, y))});
          n++;
        end
    end
    busy_lo = cyc + 1;
    done_at = (n == 0) ? cyc + 1 : cyc + n + LAT + 2;
    $display("sweep (%0d,%0d)-(%0d,%0d): %0d plots expected, done due cycle %0d%s",
             a0, b0, a1, b1, n, done_at, poke ? ", restart attempted mid-scan" : "");
    rx0 = 9'(a0); ry0 = 9'(b0); rx1 = 9'(a1); ry1 = 9'(b1);
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    if (poke && n >= 4) begin
      @(negedge clock); #1;
      rx0 = 9'($urandom_range(0, 300)); ry0 = 9'($urandom_range(0, 200));
      rx1 = 9'(319); ry1 = 9'(239);
      start = 1'b1;
      @(negedge clock); #1;
      start = 1'b0;
    end
  endtask

  // Deterministic wait: returns in the cycle after the expected done.
  task automatic finish_sweep();
    while (cyc < done_at + 1) begin
      @(negedge clock); #1;
    end
  endtask

  task automatic sweep(input int a0, input int b0, input int a1, input int b1, input bit poke);
    launch(a0, b0, a1, b1, poke);
    finish_sweep();
  endtask

  initial begin
    int a0, b0, a1, b1, c0;
    repeat (3) @(negedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock); #1;

    sweep(0, 0, 319, 239, 1'b0);
    sweep(60, 180, 63, 181, 1'b0);
    sweep(318, 238, 400, 300, 1'b0);
    sweep(50, 10, 40, 20, 1'b0);
    sweep(10, 20, 17, 22, 1'b1);

    for (int i = 0; i < 25; i++) begin
      a0 = $urandom_range(0, 325);
      b0 = $urandom_range(0, 245);
      a1 = a0 + $urandom_range(0, 10) - 2;
      b1 = b0 + $urandom_range(0, 6) - 1;
      if (a1 < 0) a1 = 0;
      if (b1 < 0) b1 = 0;
      sweep(a0, b0, a1, b1, $urandom_range(0, 1) == 1);
    end

    // Reset on the 100th cycle of a full-frame sweep, with start held high.
    c0 = cyc;
    launch(0, 0, 319, 239, 1'b0);
    while (cyc < c0 + 100) begin
      @(negedge clock); #1;
    end
    $display("reset asserted mid-sweep at cycle %0d", cyc);
    resetn = 1'b0;
    start  = 1'b1;
    rx0 = 9'(3); ry0 = 9'(4); rx1 = 9'(9); ry1 = 9'(5);
    busy_lo = -10;
    done_at = -10;
    exp_q.delete();
    repeat (4) @(negedge clock);
    #1;
    start  = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    sweep(5, 7, 12, 9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
